// File: rtl/joybus_tx_pkg.sv
// Shared joybus transmitter definitions: state encoding, stop types and
// per-symbol low-quarter counts.
package joybus_tx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_GUARD,
        ST_BIT_LOW,
        ST_BIT_HIGH,
        ST_STOP_LOW,
        ST_STOP_HIGH
    } state_t;

    localparam logic STOP_HOST = 1'b0;
    localparam logic STOP_DEV  = 1'b1;

    localparam int BIT0_LOW               = 3;
    localparam int BIT1_LOW               = 1;
    localparam int HOST_STOP_LOW          = 1;
    localparam int DEV_STOP_LOW           = 2;
    localparam int BIT_QUARTERS           = 4;
    localparam int STOP_HIGH_QUARTERS     = 2;
    localparam int MAX_BITS               = 32;
    localparam int DEFAULT_QUARTER_CYCLES = 49;

    // Low-quarter count of a data bit (isStop=0) or of a stop symbol (isStop=1).
    function automatic logic [1:0] symbolLowQuarters(input logic isStop, input logic value);
        if (isStop)
            return (value == STOP_HOST) ? 2'(HOST_STOP_LOW) : 2'(DEV_STOP_LOW);
        else
            return value ? 2'(BIT1_LOW) : 2'(BIT0_LOW);
    endfunction

endpackage

// File: rtl/joybus_quarter_timer.sv
// Free-running quarter-bit timer; restart holds it at the start of a quarter.
module joybus_quarter_timer #(
    parameter int QUARTER_CYCLES = 49
) (
    input  logic N64_CLK_i,
    input  logic CTRL_nRST,
    input  logic i_restart,
    output logic o_quarterTick,
    output logic o_midTick
);

    localparam logic [7:0] LAST_COUNT = 8'(QUARTER_CYCLES - 1);
    localparam logic [7:0] MID_COUNT  = 8'(QUARTER_CYCLES / 2);

    logic [7:0] r_cnt;

    always_ff @(posedge N64_CLK_i or negedge CTRL_nRST) begin
        if (!CTRL_nRST)
            r_cnt <= 8'd0;
        else if (i_restart || r_cnt == LAST_COUNT)
            r_cnt <= 8'd0;
        else
            r_cnt <= r_cnt + 8'd1;
    end

    assign o_quarterTick = !i_restart && (r_cnt == LAST_COUNT);
    assign o_midTick     = !i_restart && (r_cnt == MID_COUNT);

endmodule

// File: rtl/register_sync.sv
// Generic multi-bit two-flop synchronizer with a configurable reset preset.
module register_sync #(
    parameter int               WIDTH  = 1,
    parameter logic [WIDTH-1:0] PRESET = '0
) (
    input  logic             i_clk,
    input  logic             i_nRst,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_sync;

    always_ff @(posedge i_clk or negedge i_nRst) begin
        if (!i_nRst) begin
            r_meta <= PRESET;
            r_sync <= PRESET;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/joybus_tx.sv
// Joybus transmitter: guards for an idle-high line, then sends up to 32
// pulse-width encoded bits MSB first plus a host or device stop symbol.
module joybus_tx
    import joybus_tx_pkg::*;
#(
    parameter int QUARTER_CYCLES = joybus_tx_pkg::DEFAULT_QUARTER_CYCLES,
    parameter int GUARD_QUARTERS = 8
) (
    input  logic        N64_CLK_i,
    input  logic        CTRL_nRST,
    input  logic        start_i,
    input  logic [31:0] tx_data_i,
    input  logic [5:0]  tx_len_i,
    input  logic        stop_type_i,
    input  logic        CTRL_i,
    output logic        CTRL_oe_o,
    output logic        busy_o,
    output logic        done_o,
    output logic        err_o
);

    state_t      r_state, w_nextState;
    logic [31:0] r_shift, w_nextShift;
    logic [5:0]  r_bitCnt, w_nextBitCnt;
    logic        r_stopType, w_nextStopType;
    logic [1:0]  r_qCnt, w_nextQCnt;
    logic [7:0]  r_guardCnt, w_nextGuardCnt;
    logic        r_quarterHigh, w_nextQuarterHigh;
    logic        r_oe, r_busy, r_done, r_err;
    logic        w_nextDone, w_nextErr;

    logic        w_lineHigh;
    logic        w_quarterTick;
    logic        w_midTick;
    logic [1:0]  w_bitLowQ;
    logic [1:0]  w_stopLowQ;
    logic [5:0]  w_lenClamped;

    register_sync #(.WIDTH(1), .PRESET(1'b1)) u_ctrlSync (
        .i_clk  (N64_CLK_i),
        .i_nRst (CTRL_nRST),
        .i_d    (CTRL_i),
        .o_q    (w_lineHigh)
    );

    joybus_quarter_timer #(.QUARTER_CYCLES(QUARTER_CYCLES)) u_timer (
        .N64_CLK_i     (N64_CLK_i),
        .CTRL_nRST     (CTRL_nRST),
        .i_restart     (r_state == ST_IDLE),
        .o_quarterTick (w_quarterTick),
        .o_midTick     (w_midTick)
    );

    assign w_bitLowQ    = symbolLowQuarters(1'b0, r_shift[31]);
    assign w_stopLowQ   = symbolLowQuarters(1'b1, r_stopType);
    assign w_lenClamped = (tx_len_i > 6'(MAX_BITS)) ? 6'(MAX_BITS) : tx_len_i;

    always_ff @(posedge N64_CLK_i or negedge CTRL_nRST) begin
        if (!CTRL_nRST) begin
            r_state       <= ST_IDLE;
            r_shift       <= 32'd0;
            r_bitCnt      <= 6'd0;
            r_stopType    <= 1'b0;
            r_qCnt        <= 2'd0;
            r_guardCnt    <= 8'd0;
            r_quarterHigh <= 1'b0;
            r_oe          <= 1'b0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_err         <= 1'b0;
        end else begin
            r_state       <= w_nextState;
            r_shift       <= w_nextShift;
            r_bitCnt      <= w_nextBitCnt;
            r_stopType    <= w_nextStopType;
            r_qCnt        <= w_nextQCnt;
            r_guardCnt    <= w_nextGuardCnt;
            r_quarterHigh <= w_nextQuarterHigh;
            r_oe          <= (w_nextState == ST_BIT_LOW) || (w_nextState == ST_STOP_LOW);
            r_busy        <= (w_nextState != ST_IDLE);
            r_done        <= w_nextDone;
            r_err         <= w_nextErr;
        end
    end

    always_comb begin
        w_nextState       = r_state;
        w_nextShift       = r_shift;
        w_nextBitCnt      = r_bitCnt;
        w_nextStopType    = r_stopType;
        w_nextQCnt        = r_qCnt;
        w_nextGuardCnt    = r_guardCnt;
        w_nextQuarterHigh = r_quarterHigh;
        w_nextDone        = 1'b0;
        w_nextErr         = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_nextQCnt = 2'd0;
                if (start_i) begin
                    w_nextShift       = tx_data_i;
                    w_nextBitCnt      = w_lenClamped;
                    w_nextStopType    = stop_type_i;
                    w_nextGuardCnt    = 8'd0;
                    w_nextQuarterHigh = 1'b1;
                    w_nextState       = ST_GUARD;
                end
            end
            ST_GUARD: begin
                // A quarter only counts if every synchronized sample in it was high.
                w_nextQuarterHigh = r_quarterHigh & w_lineHigh;
                if (w_quarterTick) begin
                    w_nextQuarterHigh = 1'b1;
                    if (r_quarterHigh && w_lineHigh) begin
                        if (r_guardCnt == 8'(GUARD_QUARTERS - 1)) begin
                            w_nextGuardCnt = 8'd0;
                            w_nextState    = (r_bitCnt == 6'd0) ? ST_STOP_LOW : ST_BIT_LOW;
                        end else begin
                            w_nextGuardCnt = r_guardCnt + 8'd1;
                        end
                    end else begin
                        w_nextGuardCnt = 8'd0;
                    end
                end
            end
            ST_BIT_LOW: begin
                if (w_quarterTick) begin
                    if (r_qCnt == w_bitLowQ - 2'd1) begin
                        w_nextQCnt  = 2'd0;
                        w_nextState = ST_BIT_HIGH;
                    end else begin
                        w_nextQCnt = r_qCnt + 2'd1;
                    end
                end
            end
            ST_BIT_HIGH: begin
                if (w_midTick && !w_lineHigh) begin
                    w_nextErr   = 1'b1;
                    w_nextQCnt  = 2'd0;
                    w_nextState = ST_IDLE;
                end else if (w_quarterTick) begin
                    if (r_qCnt == 2'(BIT_QUARTERS - 1) - w_bitLowQ) begin
                        w_nextQCnt   = 2'd0;
                        w_nextBitCnt = r_bitCnt - 6'd1;
                        w_nextShift  = {r_shift[30:0], 1'b0};
                        w_nextState  = (r_bitCnt == 6'd1) ? ST_STOP_LOW : ST_BIT_LOW;
                    end else begin
                        w_nextQCnt = r_qCnt + 2'd1;
                    end
                end
            end
            ST_STOP_LOW: begin
                if (w_quarterTick) begin
                    if (r_qCnt == w_stopLowQ - 2'd1) begin
                        w_nextQCnt  = 2'd0;
                        w_nextState = ST_STOP_HIGH;
                    end else begin
                        w_nextQCnt = r_qCnt + 2'd1;
                    end
                end
            end
            ST_STOP_HIGH: begin
                if (w_midTick && !w_lineHigh) begin
                    w_nextErr   = 1'b1;
                    w_nextQCnt  = 2'd0;
                    w_nextState = ST_IDLE;
                end else if (w_quarterTick) begin
                    if (r_qCnt == 2'(STOP_HIGH_QUARTERS - 1)) begin
                        w_nextQCnt  = 2'd0;
                        w_nextDone  = 1'b1;
                        w_nextState = ST_IDLE;
                    end else begin
                        w_nextQCnt = r_qCnt + 2'd1;
                    end
                end
            end
            default: begin
                w_nextState = ST_IDLE;
            end
        endcase
    end

    assign CTRL_oe_o = r_oe;
    assign busy_o    = r_busy;
    assign done_o    = r_done;
    assign err_o     = r_err;

endmodule
